// File: rtl/cia_seq_wide_adder.sv
// Sequential wide adder: W=N*K operands summed one N-bit slice per cycle on a single carry-increment core.
// Latency: K+1 cycles from input handshake to out_valid; minimum initiation interval K+2.
// Backpressure: in_ready low in RUN/DONE, result held while out_ready low; CIA_SEQ_OVF_EN adds signed ovf.

module cia_adder_core #(
    parameter int N  = 16,
    parameter int GS = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int NG = (N + GS - 1) / GS;

    logic [NG:0] c;
    assign c[0] = cin;

    // Each group adds with zero carry-in, then the group carry-in increments the result.
    for (genvar g = 0; g < NG; g++) begin : grp
        localparam int LO = g * GS;
        localparam int GW = ((N - LO) < GS) ? (N - LO) : GS;

        logic [GW:0] raw;
        logic [GW:0] inc;

        assign raw = {1'b0, a[LO +: GW]} + {1'b0, b[LO +: GW]};
        assign inc = raw + {{GW{1'b0}}, c[g]};
        assign sum[LO +: GW] = inc[GW-1:0];
        assign c[g+1] = inc[GW];
    end

    assign cout = c[NG];
endmodule

module cia_seq_wide_adder #(
    parameter int N  = 16,
    parameter int GS = 8,
    parameter int K  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*K-1:0]   a,
    input  logic [N*K-1:0]   b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*K-1:0]   sum,
    output logic             cout,
    output logic             busy
`ifdef CIA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int W  = N * K;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    res;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    core_sum;
    logic            core_cout;
    logic [W+N-1:0]  res_cat;

    cia_adder_core #(
        .N  (N),
        .GS (GS)
    ) u_core (
        .a    (a_sh[N-1:0]),
        .b    (b_sh[N-1:0]),
        .cin  (carry),
        .sum  (core_sum),
        .cout (core_cout)
    );

    // New slice enters at the top; after K shifts slice 0 sits at the bottom.
    assign res_cat = {core_sum, res};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = RUN;
            RUN:     if (cnt == LAST)  state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    res   <= res_cat[W+N-1:N];
                    a_sh  <= a_sh >> N;
                    b_sh  <= b_sh >> N;
                    carry <= core_cout;
                    if (cnt != LAST) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CIA_SEQ_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_r;

    // Final slice's top bit is the sum MSB, so overflow is resolved on the DONE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_msb <= a[W-1];
            b_msb <= b[W-1];
        end else if (state == RUN && cnt == LAST) begin
            ovf_r <= (a_msb == b_msb) && (core_sum[N-1] != a_msb);
        end
    end

    assign ovf = ovf_r;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = res;
    assign cout      = carry;
endmodule
